// File: rtl/music_player_pkg.sv
// Shared types and elaboration-time helpers for the background-tune player.
package music_player_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StGap
    } state_t;

    typedef enum logic [3:0] {
        NoteRest,
        NoteC4, NoteD4, NoteE4, NoteF4, NoteG4, NoteA4, NoteB4,
        NoteC5, NoteD5, NoteE5, NoteF5, NoteG5, NoteA5, NoteB5,
        NoteC6
    } note_t;

    localparam int unsigned NUM_NOTES = 16;

    // Pitch in millihertz; 0 for REST.
    function automatic longint unsigned note_mhz(note_t n);
        longint unsigned f;
        case (n)
            NoteC4:  f = 64'd261626;
            NoteD4:  f = 64'd293660;
            NoteE4:  f = 64'd329630;
            NoteF4:  f = 64'd349230;
            NoteG4:  f = 64'd392000;
            NoteA4:  f = 64'd440000;
            NoteB4:  f = 64'd493880;
            NoteC5:  f = 64'd523250;
            NoteD5:  f = 64'd587330;
            NoteE5:  f = 64'd659260;
            NoteF5:  f = 64'd698460;
            NoteG5:  f = 64'd783990;
            NoteA5:  f = 64'd880000;
            NoteB5:  f = 64'd987770;
            NoteC6:  f = 64'd1046500;
            default: f = 64'd0;
        endcase
        return f;
    endfunction

    // round(clk_hz / (2 * f)); only ever called with constant arguments.
    function automatic int unsigned half_period(note_t n, int unsigned clk_hz);
        longint unsigned f;
        longint unsigned num;
        f = note_mhz(n);
        if (f == 64'd0) begin
            return 0;
        end
        num = 64'(clk_hz) * 64'd1000 + f;
        return 32'(num / (64'd2 * f));
    endfunction

    // Active-low key code to note; the lowest-index zero bit in [6:0] wins.
    function automatic note_t decode_key(logic [7:0] key);
        note_t n;
        n = key[7] ? NoteRest : NoteC5;
        for (int k = 6; k >= 0; k--) begin
            if (!key[k]) begin
                n = key[7] ? note_t'(4'(k + 1)) : note_t'(4'(k + 9));
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/music_player_if.sv
// Control/ROM/buzzer bundle between game control and the tune player.
interface music_player_if;
    logic       start;
    logic       stop;
    logic [7:0] key;
    logic [5:0] cnt_music;
    logic       buzzer;
    logic       busy;
    logic       done;

    modport master (
        output start, stop, key,
        input  cnt_music, buzzer, busy, done
    );

    modport slave (
        input  start, stop, key,
        output cnt_music, buzzer, busy, done
    );
endinterface

// File: rtl/music_player_tone_gen.sv
// Square-wave divider: sq toggles every `half` clocks while en is high.
module music_player_tone_gen #(
    parameter int unsigned HALF_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [HALF_W-1:0] half,
    output logic              sq
);

    logic [HALF_W-1:0] div_q;

    // Divider counts 0..half-1 and flips sq on wrap; disabling clears both.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_q <= '0;
            sq    <= 1'b0;
        end else if (div_q == half - HALF_W'(1)) begin
            div_q <= '0;
            sq    <= ~sq;
        end else begin
            div_q <= div_q + HALF_W'(1);
        end
    end

endmodule

// File: rtl/music_player.sv
// Background-tune sequencer: walks the 64-entry key ROM, one beat per index.
module music_player
    import music_player_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned BEAT_CYC = 25_000_000,
    parameter int unsigned GAP_CYC  = 2_000_000,
    parameter bit          LOOP     = 1'b1
) (
    input logic           clk,
    input logic           rst,
    music_player_if.slave bus
);

    localparam int unsigned BEAT_W   = $clog2(BEAT_CYC);
    localparam int unsigned HALF_MAX = half_period(NoteC4, CLK_HZ);
    localparam int unsigned HALF_W   = $clog2(HALF_MAX + 1);

    // Beat counter runs across PLAY and GAP so a beat is exactly BEAT_CYC clocks.
    localparam logic [BEAT_W-1:0] PLAY_LAST = BEAT_W'(BEAT_CYC - GAP_CYC - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYC - 1);

    state_t            state_q;
    logic [BEAT_W-1:0] beat_q;
    logic [5:0]        cnt_q;
    note_t             note_q;
    logic              done_q;

    logic [HALF_W-1:0] half_lut [NUM_NOTES];
    logic [HALF_W-1:0] half_sel;
    logic              tone_en;
    logic              sq;

    // Per-note half-periods are elaboration constants.
    for (genvar i = 0; i < NUM_NOTES; i++) begin : g_half
        assign half_lut[i] = HALF_W'(half_period(note_t'(4'(i)), CLK_HZ));
    end

    assign half_sel = half_lut[note_q];

    // Tone runs after the PLAY entry cycle (note_q is loaded then) and never for REST.
    assign tone_en = (state_q == StPlay) && (beat_q != '0) && (note_q != NoteRest);

    // Sequencer: stop beats everything, start only from IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            beat_q  <= '0;
            cnt_q   <= '0;
            note_q  <= NoteRest;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.stop) begin
                state_q <= StIdle;
                beat_q  <= '0;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bus.start) begin
                            state_q <= StPlay;
                            beat_q  <= '0;
                            cnt_q   <= '0;
                        end
                    end
                    StPlay: begin
                        if (beat_q == '0) begin
                            note_q <= decode_key(bus.key);
                        end
                        beat_q <= beat_q + BEAT_W'(1);
                        if (beat_q == PLAY_LAST) begin
                            state_q <= StGap;
                        end
                    end
                    StGap: begin
                        if (beat_q == BEAT_LAST) begin
                            beat_q <= '0;
                            if (cnt_q == 6'd63 && !LOOP) begin
                                state_q <= StIdle;
                                cnt_q   <= '0;
                                done_q  <= 1'b1;
                            end else begin
                                // 63 + 1 wraps to 0 for a looping tune.
                                state_q <= StPlay;
                                cnt_q   <= cnt_q + 6'd1;
                            end
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    music_player_tone_gen #(
        .HALF_W (HALF_W)
    ) u_tone (
        .clk  (clk),
        .rst  (rst),
        .en   (tone_en),
        .half (half_sel),
        .sq   (sq)
    );

    // Gate with tone_en so the first GAP cycle is silent before the divider clears.
    assign bus.buzzer    = sq & tone_en;
    assign bus.cnt_music = cnt_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_music_player.sv
// Bench for music_player: tone table on a 1 MHz instance, model-checked random tunes
// on two fast instances (looping and one-shot).
module tb_music_player;

    localparam int unsigned M_CLK  = 1_000_000;
    localparam int unsigned M_BEAT = 4000;
    localparam int unsigned M_GAP  = 400;
    localparam int unsigned M_PLAY = M_BEAT - M_GAP;
    localparam int unsigned R_CLK  = 20_000;
    localparam int unsigned R_BEAT = 120;
    localparam int unsigned R_GAP  = 20;
    localparam int unsigned R_PLAY = R_BEAT - R_GAP;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    music_player_if m_if ();
    music_player_if r_if ();
    music_player_if z_if ();

    music_player #(
        .CLK_HZ (M_CLK), .BEAT_CYC (M_BEAT), .GAP_CYC (M_GAP), .LOOP (1'b1)
    ) u_main (
        .clk (clk), .rst (rst), .bus (m_if)
    );

    music_player #(
        .CLK_HZ (R_CLK), .BEAT_CYC (R_BEAT), .GAP_CYC (R_GAP), .LOOP (1'b1)
    ) u_rnd (
        .clk (clk), .rst (rst), .bus (r_if)
    );

    music_player #(
        .CLK_HZ (R_CLK), .BEAT_CYC (R_BEAT), .GAP_CYC (R_GAP), .LOOP (1'b0)
    ) u_once (
        .clk (clk), .rst (rst), .bus (z_if)
    );

    // Key ROMs: combinational lookup of the presented index.
    logic [7:0] rom_main [64];
    logic [7:0] rom_rnd  [64];
    logic       force_en;
    logic [7:0] force_key;

    always_comb m_if.key = force_en ? force_key : rom_main[m_if.cnt_music];
    always_comb r_if.key = rom_rnd[r_if.cnt_music];
    always_comb z_if.key = rom_rnd[z_if.cnt_music];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    // Reference pitches in Hz, C4 .. C6.
    function automatic real note_hz(input int i);
        case (i)
            0: return 261.626;  1: return 293.66;  2: return 329.63;  3: return 349.23;
            4: return 392.0;    5: return 440.0;   6: return 493.88;  7: return 523.25;
            8: return 587.33;   9: return 659.26;  10: return 698.46; 11: return 783.99;
            12: return 880.0;   13: return 987.77; default: return 1046.5;
        endcase
    endfunction

    // Pitch number from a key code, -1 for REST.
    function automatic int note_idx(input logic [7:0] k);
        for (int b = 0; b < 7; b++) begin
            if (k[b] == 1'b0) return k[7] ? b : 8 + b;
        end
        return k[7] ? -1 : 7;
    endfunction

    function automatic int model_half(input logic [7:0] k, input int clk_hz);
        int i;
        i = note_idx(k);
        if (i < 0) return 0;
        return $rtoi(real'(clk_hz) / (2.0 * note_hz(i)) + 0.5);
    endfunction

    // Buzzer level at offset o into a beat: silent on entry, in the gap and for REST.
    function automatic int model_buzzer(input int o, input int half, input int play_cyc);
        if (half == 0 || o < 1 || o >= play_cyc) return 0;
        return ((o - 1) / half) % 2;
    endfunction

    typedef struct {
        logic [7:0] key;
        int         half;
        bit         poke_start;
    } vec_t;

    vec_t vecs [6];

    // Walks one main beat starting at the negedge of its PLAY entry cycle.
    task automatic scan_beat(input vec_t v, input logic [7:0] next_key, input int exp_idx);
        int rise, fall, noise, cnt_bad, exp_fall;
        rise = -1; fall = -1; noise = 0; cnt_bad = 0;
        for (int o = 0; o < int'(M_BEAT); o++) begin
            if (o == 100 && v.poke_start) m_if.start = 1'b1;
            if (o == 101) m_if.start = 1'b0;
            if (o == int'(M_BEAT) - 10) force_key = next_key;
            if (m_if.buzzer === 1'b1 && rise < 0) rise = o;
            if (m_if.buzzer === 1'b0 && rise >= 0 && fall < 0) fall = o;
            if (m_if.buzzer !== 1'b0 && (o == 0 || o >= int'(M_PLAY))) noise++;
            if (int'(m_if.cnt_music) != exp_idx) cnt_bad++;
            @(negedge clk);
        end
        if (v.half == 0) exp_fall = -1;
        else exp_fall = (2 * v.half + 1 < int'(M_PLAY)) ? 2 * v.half + 1 : int'(M_PLAY);
        check("tone_first_rise", rise, (v.half == 0) ? -1 : v.half + 1);
        check("tone_first_fall", fall, exp_fall);
        check("silent_entry_gap", noise, 0);
        check("cnt_stable_in_beat", cnt_bad, 0);
        check("cnt_after_beat", m_if.cnt_music, (exp_idx + 1) % 64);
        check("busy_after_beat", m_if.busy, 1);
    endtask

    initial begin
        int beat, o, idx, h, zb, dones, busies;

        rst = 1'b1;
        force_en = 1'b1;
        force_key = 8'hfd;
        m_if.start = 1'b0; m_if.stop = 1'b0;
        r_if.start = 1'b0; r_if.stop = 1'b0;
        z_if.start = 1'b0; z_if.stop = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rom_main[i] = 8'hfd;
            rom_rnd[i]  = 8'($urandom);
        end
        rom_rnd[5]  = 8'hff;
        rom_rnd[9]  = 8'h7f;
        rom_rnd[63] = 8'hbf;

        vecs[0] = '{key: 8'hfd, half: 1703, poke_start: 1'b0};
        vecs[1] = '{key: 8'hdf, half: 1136, poke_start: 1'b1};
        vecs[2] = '{key: 8'h7f, half: 956,  poke_start: 1'b0};
        vecs[3] = '{key: 8'hff, half: 0,    poke_start: 1'b0};
        vecs[4] = '{key: 8'hfe, half: 1911, poke_start: 1'b0};
        vecs[5] = '{key: 8'h3f, half: 478,  poke_start: 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_cnt", m_if.cnt_music, 0);
        check("reset_buzzer", m_if.buzzer, 0);
        check("reset_busy", m_if.busy, 0);
        check("reset_done", m_if.done, 0);

        // Random tunes: looping and one-shot instances run side by side.
        r_if.start = 1'b1; z_if.start = 1'b1;
        @(negedge clk);
        r_if.start = 1'b0; z_if.start = 1'b0;
        for (int t = 0; t < 65 * int'(R_BEAT); t++) begin
            beat = t / int'(R_BEAT);
            o    = t % int'(R_BEAT);
            idx  = beat % 64;
            h    = model_half(rom_rnd[idx], int'(R_CLK));
            check("loop_cnt", r_if.cnt_music, idx);
            check("loop_busy", r_if.busy, 1);
            check("loop_done", r_if.done, 0);
            check("loop_buzzer", r_if.buzzer, model_buzzer(o, h, int'(R_PLAY)));
            if (beat < 64) begin
                check("once_cnt", z_if.cnt_music, idx);
                check("once_busy", z_if.busy, 1);
                check("once_done", z_if.done, 0);
                check("once_buzzer", z_if.buzzer, model_buzzer(o, h, int'(R_PLAY)));
            end else begin
                zb = (t == 64 * int'(R_BEAT)) ? 1 : 0;
                check("once_end_done", z_if.done, zb);
                check("once_end_busy", z_if.busy, 0);
                check("once_end_cnt", z_if.cnt_music, 0);
                check("once_end_buzzer", z_if.buzzer, 0);
            end
            @(negedge clk);
        end

        // Stop together with start in the middle of index 20.
        repeat (19 * int'(R_BEAT) + 50) @(negedge clk);
        check("pre_stop_cnt", r_if.cnt_music, 20);
        check("pre_stop_busy", r_if.busy, 1);
        r_if.start = 1'b1; r_if.stop = 1'b1;
        @(negedge clk);
        r_if.start = 1'b0; r_if.stop = 1'b0;
        check("stop_busy", r_if.busy, 0);
        check("stop_buzzer", r_if.buzzer, 0);
        check("stop_cnt", r_if.cnt_music, 0);
        check("stop_done", r_if.done, 0);
        dones = 0; busies = 0;
        repeat (3 * int'(R_BEAT)) begin
            @(negedge clk);
            if (r_if.done !== 1'b0) dones++;
            if (r_if.busy !== 1'b0) busies++;
        end
        check("stop_no_done", dones, 0);
        check("stop_stays_idle", busies, 0);

        // Main instance: tone table, with a start poke during one PLAY.
        m_if.start = 1'b1;
        @(negedge clk);
        m_if.start = 1'b0;
        check("main_first_cnt", m_if.cnt_music, 0);
        check("main_first_busy", m_if.busy, 1);
        for (int j = 0; j < 6; j++) begin
            scan_beat(vecs[j], (j < 5) ? vecs[j + 1].key : 8'hfd, j);
        end

        // Reset in the middle of a GAP, then replay from index 0.
        repeat (M_PLAY + 100) @(negedge clk);
        check("pre_rst_busy", m_if.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_gap_cnt", m_if.cnt_music, 0);
        check("rst_gap_busy", m_if.busy, 0);
        check("rst_gap_buzzer", m_if.buzzer, 0);
        check("rst_gap_done", m_if.done, 0);
        rst = 1'b0;
        force_key = 8'hfd;
        repeat (20) @(negedge clk);
        check("post_rst_idle", m_if.busy, 0);
        m_if.start = 1'b1;
        @(negedge clk);
        m_if.start = 1'b0;
        check("replay_cnt", m_if.cnt_music, 0);
        scan_beat(vecs[0], 8'hfd, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
